lock_in_demodulator_mc: RTL and testbench

Multi-channel, decimating successor to the single-channel lock-in amplifier. One time-multiplexed multiplier demodulates NUM_CHANNELS noisy input channels against a shared in-phase and quadrature reference. The reference comes from the existing Hilbert/delay-line front end, already phase-aligned. Products are integrated over 2**LOG2_DEC ticks and dumped as per-channel X/Y with a done strobe. The block sits between the sample-rate front end and the readout.

---
 rtl/lock_in_pkg.sv | 26 ++
 rtl/lock_in_mac.sv | 52 +++++
 rtl/lock_in_demodulator_mc.sv | 157 +++++++++++++++
 tb/tb_lock_in_demodulator_mc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_in_pkg.sv
// Shared types and fixed-point helpers for the multi-channel lock-in demodulator.
package lock_in_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DUMP} state_t;

    localparam int NUM_BITS_DEF     = 24;
    localparam int NUM_CHANNELS_DEF = 4;
    localparam int LOG2_DEC_DEF     = 3;
    localparam int ACC_W_DEF        = NUM_BITS_DEF + LOG2_DEC_DEF;

    function automatic int acc_width(input int num_bits, input int log2_dec);
        return num_bits + log2_dec;
    endfunction

    // Rescale a Q2.(2n-2) product back to Q1.(n-1); only (-1)*(-1) exceeds the range.
    function automatic logic signed [63:0] scale_sat(input logic signed [63:0] prod,
                                                     input int num_bits);
        logic signed [63:0] s;
        logic signed [63:0] max_v;
        s     = prod >>> (num_bits - 1);
        max_v = (64'sd1 <<< (num_bits - 1)) - 64'sd1;
        if (s > max_v) s = max_v;
        return s;
    endfunction

endpackage

// File: rtl/lock_in_mac.sv
// Shared multiplier: selects reference/channel from the step index and registers the scaled product.
module lock_in_mac
    import lock_in_pkg::*;
#(
    parameter int NUM_BITS     = NUM_BITS_DEF,
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    localparam int KW = $clog2(2 * NUM_CHANNELS),
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       clear_i,
    input  logic                       vld_p0,
    input  logic [KW-1:0]              k_p0,
    input  logic signed [NUM_BITS-1:0] ref_inph,
    input  logic signed [NUM_BITS-1:0] ref_quad,
    input  logic signed [NUM_BITS-1:0] sig [NUM_CHANNELS],
    output logic signed [NUM_BITS-1:0] prod_p1,
    output logic [CW-1:0]              ch_p1,
    output logic                       quad_p1,
    output logic                       vld_p1
);

    logic [CW-1:0]                ch_p0;
    logic                         quad_p0;
    logic signed [NUM_BITS-1:0]   mul_a;
    logic signed [NUM_BITS-1:0]   mul_b;
    logic signed [2*NUM_BITS-1:0] prod_full;
    logic signed [NUM_BITS-1:0]   prod_p0;

    always_comb begin
        ch_p0     = CW'(k_p0 >> 1);
        quad_p0   = k_p0[0];
        mul_a     = quad_p0 ? ref_quad : ref_inph;
        mul_b     = sig[ch_p0];
        prod_full = mul_a * mul_b;
        prod_p0   = NUM_BITS'(scale_sat(64'(prod_full), NUM_BITS));
    end

    // p0 -> p1: registered product with its accumulator select
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) vld_p1 <= 1'b0;
        else           vld_p1 <= vld_p0 && !clear_i;
    end

    always_ff @(posedge clk_i) begin
        prod_p1 <= prod_p0;
        ch_p1   <= ch_p0;
        quad_p1 <= quad_p0;
    end

endmodule

// File: rtl/lock_in_demodulator_mc.sv
// Time-multiplexed I/Q lock-in demodulator with integrate-and-dump decimation over 2**LOG2_DEC ticks.
module lock_in_demodulator_mc
    import lock_in_pkg::*;
#(
    parameter int NUM_BITS     = NUM_BITS_DEF,
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int LOG2_DEC     = LOG2_DEC_DEF
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       tick_i,
    input  logic                       clear_i,
    input  logic signed [NUM_BITS-1:0] ref_inph_i,
    input  logic signed [NUM_BITS-1:0] ref_quad_i,
    input  logic signed [NUM_BITS-1:0] sig_i [NUM_CHANNELS],
    output logic signed [NUM_BITS-1:0] x_o [NUM_CHANNELS],
    output logic signed [NUM_BITS-1:0] y_o [NUM_CHANNELS],
    output logic                       done_o,
    output logic                       busy_o,
    output logic                       overrun_o
);

    localparam int ACC_W = acc_width(NUM_BITS, LOG2_DEC);
    localparam int KW    = $clog2(2 * NUM_CHANNELS);
    localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam logic [KW-1:0]    K_LAST   = KW'(2 * NUM_CHANNELS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DEC) - 1);

    state_t                     state;
    state_t                     state_nxt;
    logic [KW-1:0]              k;
    logic [KW-1:0]              k_nxt;
    logic [CNT_W-1:0]           cnt;
    logic signed [NUM_BITS-1:0] ref_inph_lat;
    logic signed [NUM_BITS-1:0] ref_quad_lat;
    logic signed [NUM_BITS-1:0] sig_lat [NUM_CHANNELS];
    logic signed [ACC_W-1:0]    acc_i [NUM_CHANNELS];
    logic signed [ACC_W-1:0]    acc_q [NUM_CHANNELS];
    logic signed [NUM_BITS-1:0] prod_p1;
    logic signed [ACC_W-1:0]    prod_ext_p1;
    logic [CW-1:0]              ch_p1;
    logic                       quad_p1;
    logic                       vld_p1;
    logic                       accept;
    logic                       dumping;

    assign accept      = (state == IDLE) && tick_i && !clear_i;
    assign dumping     = (state == DUMP) && !clear_i;
    assign busy_o      = (state != IDLE);
    assign prod_ext_p1 = ACC_W'(prod_p1);

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        case (state)
            IDLE:  if (tick_i) begin
                       state_nxt = RUN;
                       k_nxt     = '0;
                   end
            RUN:   if (k == K_LAST) state_nxt = DRAIN;
                   else             k_nxt     = k + KW'(1);
            DRAIN: state_nxt = (cnt == CNT_LAST) ? DUMP : IDLE;
            DUMP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt       <= '0;
            overrun_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= dumping;
            if (clear_i) begin
                cnt       <= '0;
                overrun_o <= 1'b0;
            end else begin
                if (tick_i && busy_o) overrun_o <= 1'b1;
                if (state == DUMP)                          cnt <= '0;
                else if (state == DRAIN && cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Operands are held from the accepted tick so the inputs may move during the sweep
    always_ff @(posedge clk_i) begin
        if (accept) begin
            ref_inph_lat <= ref_inph_i;
            ref_quad_lat <= ref_quad_i;
            for (int c = 0; c < NUM_CHANNELS; c++) sig_lat[c] <= sig_i[c];
        end
    end

    lock_in_mac #(
        .NUM_BITS    (NUM_BITS),
        .NUM_CHANNELS(NUM_CHANNELS)
    ) u_mac (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .clear_i (clear_i),
        .vld_p0  (state == RUN),
        .k_p0    (k),
        .ref_inph(ref_inph_lat),
        .ref_quad(ref_quad_lat),
        .sig     (sig_lat),
        .prod_p1 (prod_p1),
        .ch_p1   (ch_p1),
        .quad_p1 (quad_p1),
        .vld_p1  (vld_p1)
    );

    // p1 -> p2: accumulate the registered product
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                acc_i[c] <= '0;
                acc_q[c] <= '0;
            end
        end else if (clear_i || state == DUMP) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                acc_i[c] <= '0;
                acc_q[c] <= '0;
            end
        end else if (vld_p1) begin
            if (quad_p1) acc_q[ch_p1] <= acc_q[ch_p1] + prod_ext_p1;
            else         acc_i[ch_p1] <= acc_i[ch_p1] + prod_ext_p1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                x_o[c] <= '0;
                y_o[c] <= '0;
            end
        end else if (dumping) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                x_o[c] <= NUM_BITS'(acc_i[c] >>> LOG2_DEC);
                y_o[c] <= NUM_BITS'(acc_q[c] >>> LOG2_DEC);
            end
        end
    end

endmodule

// File: tb/tb_lock_in_demodulator_mc.sv
// Randomized bench for lock_in_demodulator_mc against a tick-level behavioural model.
module tb_lock_in_demodulator_mc;

    localparam int NB  = 24;
    localparam int NC  = 4;
    localparam int L2  = 3;
    localparam int DEC = 1 << L2;
    localparam longint MAXV = (64'sd1 <<< (NB - 1)) - 64'sd1;

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;
    logic tick_i   = 1'b0;
    logic clear_i  = 1'b0;
    logic signed [NB-1:0] ref_inph_i = '0;
    logic signed [NB-1:0] ref_quad_i = '0;
    logic signed [NB-1:0] sig_i [NC];
    logic signed [NB-1:0] x_o [NC];
    logic signed [NB-1:0] y_o [NC];
    logic done_o, busy_o, overrun_o;

    int total = 0;
    int bad   = 0;

    lock_in_demodulator_mc #(
        .NUM_BITS    (NB),
        .NUM_CHANNELS(NC),
        .LOG2_DEC    (L2)
    ) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .tick_i    (tick_i),
        .clear_i   (clear_i),
        .ref_inph_i(ref_inph_i),
        .ref_quad_i(ref_quad_i),
        .sig_i     (sig_i),
        .x_o       (x_o),
        .y_o       (y_o),
        .done_o    (done_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(input string name, input logic signed [63:0] act,
                                input logic signed [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // ---------------- behavioural model ----------------
    longint cyc = 0;
    longint busy_end = -1;
    longint done_cyc = -1;
    int     nacc = 0;
    bit     m_over = 1'b0;
    bit     exp_done;
    longint sum_i [NC];
    longint sum_q [NC];
    longint pend_x [NC];
    longint pend_y [NC];
    longint exp_x [NC];
    longint exp_y [NC];

    function automatic longint mprod(input longint a, input longint b);
        longint p;
        p = (a * b) >>> (NB - 1);
        if (p > MAXV) p = MAXV;
        return p;
    endfunction

    always @(negedge clk_i) begin
        if (!reset_ni) begin
            busy_end = -1;
            done_cyc = -1;
            nacc     = 0;
            m_over   = 1'b0;
            for (int c = 0; c < NC; c++) begin
                sum_i[c] = 0; sum_q[c] = 0; pend_x[c] = 0; pend_y[c] = 0;
                exp_x[c] = 0; exp_y[c] = 0;
            end
        end
        exp_done = (cyc == done_cyc);
        if (exp_done)
            for (int c = 0; c < NC; c++) begin
                exp_x[c] = pend_x[c];
                exp_y[c] = pend_y[c];
            end
        chk("done_o", done_o, exp_done);
        chk("busy_o", busy_o, cyc <= busy_end);
        chk("overrun_o", overrun_o, m_over);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("x_o[%0d]", c), x_o[c], exp_x[c]);
            chk($sformatf("y_o[%0d]", c), y_o[c], exp_y[c]);
        end
        if (reset_ni) begin
            if (clear_i) begin
                if (busy_end > cyc) busy_end = cyc;
                if (done_cyc > cyc) done_cyc = -1;
                nacc   = 0;
                m_over = 1'b0;
                for (int c = 0; c < NC; c++) begin
                    sum_i[c] = 0; sum_q[c] = 0;
                end
            end else if (tick_i) begin
                if (cyc <= busy_end) begin
                    m_over = 1'b1;
                end else begin
                    for (int c = 0; c < NC; c++) begin
                        sum_i[c] += mprod(ref_inph_i, sig_i[c]);
                        sum_q[c] += mprod(ref_quad_i, sig_i[c]);
                    end
                    nacc++;
                    busy_end = cyc + 2 * NC + 1;
                    if (nacc == DEC) begin
                        busy_end = busy_end + 1;
                        done_cyc = cyc + 2 * NC + 3;
                        for (int c = 0; c < NC; c++) begin
                            pend_x[c] = sum_i[c] >>> L2;
                            pend_y[c] = sum_q[c] >>> L2;
                            sum_i[c] = 0; sum_q[c] = 0;
                        end
                        nacc = 0;
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    logic signed [NB-1:0] cur_ri, cur_rq;
    logic signed [NB-1:0] cur_s [NC];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic signed [NB-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 24'sh800000;
            1:       return 24'sh7FFFFF;
            2:       return '0;
            default: return NB'($urandom);
        endcase
    endfunction

    task automatic scramble();
        ref_inph_i = NB'($urandom);
        ref_quad_i = NB'($urandom);
        for (int c = 0; c < NC; c++) sig_i[c] = NB'($urandom);
    endtask

    task automatic set_in(input logic signed [NB-1:0] ri, input logic signed [NB-1:0] rq,
                          input logic signed [NB-1:0] s0, input logic signed [NB-1:0] s1,
                          input logic signed [NB-1:0] s2, input logic signed [NB-1:0] s3);
        cur_ri = ri; cur_rq = rq;
        cur_s[0] = s0; cur_s[1] = s1; cur_s[2] = s2; cur_s[3] = s3;
    endtask

    task automatic pulse(input int spacing);
        ref_inph_i = cur_ri;
        ref_quad_i = cur_rq;
        for (int c = 0; c < NC; c++) sig_i[c] = cur_s[c];
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        scramble();
        repeat (spacing - 1) step();
    endtask

    initial begin
        for (int c = 0; c < NC; c++) sig_i[c] = '0;
        repeat (3) step();
        chk("reset x_o[0]", x_o[0], 0);
        chk("reset busy_o", busy_o, 0);
        chk("reset done_o", done_o, 0);
        chk("reset overrun_o", overrun_o, 0);
        reset_ni = 1'b1;
        step();

        // half-scale in-phase tone on channel 0
        set_in(24'sh400000, 24'sh000000, 24'sh400000, 24'sh0, 24'sh0, 24'sh0);
        repeat (DEC) pulse(11);
        chk("s2 done_o", done_o, 1);
        chk("s2 x_o[0]", x_o[0], 24'sh200000);
        chk("s2 y_o[0]", y_o[0], 0);
        chk("s2 x_o[1]", x_o[1], 0);
        step();
        chk("s2 done width", done_o, 0);

        // reset in the middle of a sweep
        repeat (3) pulse(11);
        pulse(4);
        reset_ni = 1'b0;
        #2;
        chk("s1 async x_o[0]", x_o[0], 0);
        chk("s1 async busy_o", busy_o, 0);
        step();
        step();
        reset_ni = 1'b1;
        step();
        repeat (DEC - 1) pulse(11);
        chk("s1 no early done", done_o, 0);
        pulse(11);
        chk("s1 done_o", done_o, 1);
        chk("s1 x_o[0]", x_o[0], 24'sh200000);

        // (-1)*(-1) saturation
        set_in(24'sh800000, 24'sh800000, 24'sh0, 24'sh0, 24'sh800000, 24'sh0);
        repeat (DEC) pulse(11);
        chk("s3 x_o[2]", x_o[2], 24'sh7FFFFF);
        chk("s3 y_o[2]", y_o[2], 24'sh7FFFFF);

        // floor rounding of tiny products
        set_in(24'sd1, 24'sd1, 24'sh0, -24'sd1, 24'sh0, 24'sh0);
        repeat (DEC) pulse(11);
        chk("s4 x_o[1] neg", x_o[1], -1);
        set_in(24'sd1, 24'sd1, 24'sh0, 24'sd1, 24'sh0, 24'sh0);
        repeat (DEC) pulse(11);
        chk("s4 x_o[1] pos", x_o[1], 0);

        // dropped tick sets overrun and does not count
        set_in(24'sh400000, 24'sh000000, 24'sh400000, 24'sh0, 24'sh0, 24'sh0);
        pulse(5);
        pulse(6);
        chk("s5 overrun_o", overrun_o, 1);
        repeat (DEC - 1) pulse(11);
        chk("s5 done_o", done_o, 1);
        chk("s5 x_o[0]", x_o[0], 24'sh200000);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("s5 overrun cleared", overrun_o, 0);
        step();

        // clear with a coincident tick restarts the window
        set_in(24'sh7FFFFF, 24'sh0, 24'sh0, 24'sh0, 24'sh0, 24'sh7FFFFF);
        repeat (4) pulse(11);
        ref_inph_i = cur_ri;
        sig_i[3] = cur_s[3];
        clear_i = 1'b1;
        tick_i  = 1'b1;
        step();
        clear_i = 1'b0;
        tick_i  = 1'b0;
        step();
        set_in(24'sh7FFFFF, 24'sh0, 24'sh0, 24'sh0, 24'sh0, 24'sh100000);
        repeat (DEC) pulse(11);
        chk("s6 done_o", done_o, 1);
        chk("s6 x_o[3]", x_o[3], 24'sh0FFFFF);
        chk("s6 overrun_o", overrun_o, 0);

        // randomized traffic with occasional clears and dense ticks
        repeat (250) begin
            if ($urandom_range(0, 19) == 0) begin
                clear_i = 1'b1;
                tick_i  = 1'($urandom_range(0, 1));
                step();
                clear_i = 1'b0;
                tick_i  = 1'b0;
                step();
            end else begin
                set_in(pick(), pick(), pick(), pick(), pick(), pick());
                pulse($urandom_range(6, 14));
            end
        end

        repeat (30) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
